// File: rtl/scan_wr_packer.sv
// rtl/scan_wr_packer.sv - packs reader samples into words and issues fixed-length SDRAM write bursts
// Word FIFO with show-ahead head, frame address generator and IDLE/REQ/BURST handshake FSM.
module scan_wr_packer #(
  parameter int IN_W       = 8,
  parameter int OUT_W      = 16,
  parameter int PACK_MODE  = 0,
  parameter int FIFO_DEPTH = 64,
  parameter int BURST_LEN  = 32,
  parameter int MAX_ADDR   = 1843200
) (
  input  logic                          CLK,
  input  logic                          RESET_N,
  input  logic [IN_W-1:0]               IN_DATA,
  input  logic                          IN_VALID,
  output logic                          IN_READY,
  input  logic [23:0]                   BASE_ADDR,
  input  logic                          FRAME_START,
  output logic                          WR_REQ,
  output logic [23:0]                   WR_ADDR,
  input  logic                          WR_ACK,
  input  logic                          WR_POP,
  output logic [OUT_W-1:0]              WR_DATA,
  output logic [$clog2(FIFO_DEPTH):0]   LEVEL,
  output logic                          ERR
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LANES = OUT_W / IN_W;
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CW    = $clog2(BURST_LEN) + 1;

  localparam logic [AW:0]   LVL_FULL  = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   LVL_BURST = (AW+1)'(BURST_LEN);
  localparam logic [CW-1:0] CNT_LAST  = CW'(BURST_LEN - 1);
  localparam logic [LW-1:0] LANE_LAST = LW'(LANES - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_BURST = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [23:0]      addr_q, addr_d;
  logic [23:0]      pend_base_q, pend_base_d;
  logic             restart_q, restart_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             live_q, live_d;
  logic [LW-1:0]    lane_q, lane_d;
  logic [OUT_W-1:0] pack_q, pack_d;
  logic [AW:0]      level_q, level_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [OUT_W-1:0] mem_q [FIFO_DEPTH];

  logic             full, empty, in_ready, xfer;
  logic             pop_ok, burst_done, restart_now, apply_restart, discard_pack;
  logic             push;
  logic [OUT_W-1:0] push_word;
  logic [OUT_W-1:0] word;
  logic [LW-1:0]    cur_lane;
  logic [31:0]      adv;

  assign full          = (level_q == LVL_FULL);
  assign empty         = (level_q == '0);
  assign in_ready      = live_q & ~full;
  assign xfer          = IN_VALID & in_ready;
  assign pop_ok        = WR_POP & (state_q == ST_BURST) & ~empty;
  assign burst_done    = pop_ok & (cnt_q == CNT_LAST);
  assign restart_now   = FRAME_START & (state_q != ST_BURST);
  // A restart requested during a burst takes effect on its final pop.
  assign apply_restart = burst_done & (restart_q | FRAME_START);
  assign discard_pack  = restart_now | apply_restart;
  assign adv           = {8'd0, addr_q} + 32'(BURST_LEN);

  always_comb begin
    push      = 1'b0;
    push_word = '0;
    lane_d    = lane_q;
    pack_d    = pack_q;
    word      = discard_pack ? '0 : pack_q;
    cur_lane  = discard_pack ? '0 : lane_q;
    if (discard_pack) begin
      lane_d = '0;
      pack_d = '0;
    end
    if (xfer) begin
      if (PACK_MODE == 0) begin
        push      = 1'b1;
        push_word = OUT_W'(IN_DATA);
      end else begin
        // A sample arriving with a restart becomes lane 0 of the new frame.
        for (int i = 0; i < LANES; i++) begin
          if (cur_lane == LW'(i)) word[i*IN_W +: IN_W] = IN_DATA;
        end
        if (cur_lane == LANE_LAST) begin
          push      = 1'b1;
          push_word = word;
          lane_d    = '0;
          pack_d    = '0;
        end else begin
          lane_d = cur_lane + LW'(1);
          pack_d = word;
        end
      end
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    level_d  = level_q;
    if (push && !pop_ok) level_d = level_q + (AW+1)'(1);
    if (!push && pop_ok) level_d = level_q - (AW+1)'(1);
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    pend_base_d = pend_base_q;
    restart_d   = restart_q;
    cnt_d       = cnt_q;
    live_d      = 1'b1;
    err_d       = err_q | (WR_POP & ~pop_ok);
    case (state_q)
      ST_IDLE: begin
        if (FRAME_START) addr_d = BASE_ADDR;
        else if (level_q >= LVL_BURST) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (FRAME_START) begin
          addr_d  = BASE_ADDR;
          state_d = ST_IDLE;
        end else if (WR_ACK) begin
          state_d = ST_BURST;
        end
      end
      ST_BURST: begin
        if (FRAME_START) begin
          restart_d   = 1'b1;
          pend_base_d = BASE_ADDR;
        end
        if (pop_ok) cnt_d = cnt_q + CW'(1);
        if (burst_done) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          restart_d = 1'b0;
          if (apply_restart) addr_d = FRAME_START ? BASE_ADDR : pend_base_q;
          else if (adv + 32'(BURST_LEN) > 32'(MAX_ADDR)) addr_d = BASE_ADDR;
          else addr_d = adv[23:0];
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      pend_base_q <= '0;
      restart_q   <= 1'b0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      live_q      <= 1'b0;
      lane_q      <= '0;
      pack_q      <= '0;
      level_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      pend_base_q <= pend_base_d;
      restart_q   <= restart_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      live_q      <= live_d;
      lane_q      <= lane_d;
      pack_q      <= pack_d;
      level_q     <= level_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= push_word;
  end

  assign IN_READY = in_ready;
  assign WR_REQ   = (state_q == ST_REQ);
  assign WR_ADDR  = addr_q;
  assign WR_DATA  = empty ? '0 : mem_q[rd_ptr_q];
  assign LEVEL    = level_q;
  assign ERR      = err_q;

endmodule

// File: tb/tb_scan_wr_packer.sv
// tb/tb_scan_wr_packer.sv - directed/random bench for scan_wr_packer in both pack modes
// Expected words and burst addresses come from a queue-and-arithmetic frame model.
module tb_scan_wr_packer;

  localparam int BL   = 32;
  localparam int MAX0 = 96;

  logic        CLK = 1'b0;
  logic        rst_n;

  logic [7:0]  in_data0, in_data1;
  logic        in_valid0, in_valid1, in_ready0, in_ready1;
  logic [23:0] base0, base1, wr_addr0, wr_addr1;
  logic        fs0, fs1, wr_req0, wr_req1, wr_ack0, wr_ack1, wr_pop0, wr_pop1;
  logic [15:0] wr_data0, wr_data1;
  logic [6:0]  level0, level1;
  logic        err0, err1;

  int          n_cmp = 0;
  int          n_bad = 0;

  logic [15:0] q0[$];
  logic [15:0] q1[$];
  int unsigned m_addr, m_base, m_pops;
  bit          m_restart;

  always #5 CLK = ~CLK;

  scan_wr_packer #(.PACK_MODE(0), .MAX_ADDR(MAX0)) dut0 (
    .CLK(CLK), .RESET_N(rst_n), .IN_DATA(in_data0), .IN_VALID(in_valid0), .IN_READY(in_ready0),
    .BASE_ADDR(base0), .FRAME_START(fs0), .WR_REQ(wr_req0), .WR_ADDR(wr_addr0), .WR_ACK(wr_ack0),
    .WR_POP(wr_pop0), .WR_DATA(wr_data0), .LEVEL(level0), .ERR(err0)
  );

  scan_wr_packer #(.PACK_MODE(1)) dut1 (
    .CLK(CLK), .RESET_N(rst_n), .IN_DATA(in_data1), .IN_VALID(in_valid1), .IN_READY(in_ready1),
    .BASE_ADDR(base1), .FRAME_START(fs1), .WR_REQ(wr_req1), .WR_ADDR(wr_addr1), .WR_ACK(wr_ack1),
    .WR_POP(wr_pop1), .WR_DATA(wr_data1), .LEVEL(level1), .ERR(err1)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Address the next burst should use once the current one has drained.
  task automatic model_burst_done();
    if (m_restart) begin
      m_addr    = m_base;
      m_restart = 1'b0;
    end else begin
      m_addr = m_addr + BL;
      if (m_addr + BL > MAX0) m_addr = m_base;
    end
    m_pops = 0;
  endtask

  task automatic push0(input logic [7:0] d);
    in_data0  = d;
    in_valid0 = 1'b1;
    tick();
    in_valid0 = 1'b0;
    q0.push_back({8'h00, d});
  endtask

  task automatic push1(input logic [7:0] d);
    in_data1  = d;
    in_valid1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
  endtask

  task automatic start_burst0(input string tag);
    int w;
    w = 0;
    while (!wr_req0 && w < 50) begin
      tick();
      w++;
    end
    chk({tag, "_req"}, 32'(wr_req0), 32'd1);
    chk({tag, "_addr"}, 32'(wr_addr0), m_addr);
    wr_ack0 = 1'b1;
    tick();
    wr_ack0 = 1'b0;
    chk({tag, "_req_drop"}, 32'(wr_req0), 32'd0);
  endtask

  task automatic pops0(input int n);
    logic [15:0] e;
    for (int i = 0; i < n; i++) begin
      e = (q0.size() > 0) ? q0.pop_front() : 16'h0000;
      chk("wr_data0", 32'(wr_data0), 32'(e));
      wr_pop0 = 1'b1;
      tick();
      wr_pop0 = 1'b0;
      m_pops++;
      if (m_pops == BL) model_burst_done();
    end
  endtask

  initial begin
    logic [7:0] lo, hi, held;
    int w;
    rst_n = 1'b0;
    in_data0 = '0; in_valid0 = 0; base0 = '0; fs0 = 0; wr_ack0 = 0; wr_pop0 = 0;
    in_data1 = '0; in_valid1 = 0; base1 = '0; fs1 = 0; wr_ack1 = 0; wr_pop1 = 0;
    m_addr = 0; m_base = 0; m_pops = 0; m_restart = 0;
    repeat (3) tick();
    chk("rst_in_ready", 32'(in_ready0), 32'd0);
    chk("rst_wr_req", 32'(wr_req0), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr0), 32'd0);
    chk("rst_level", 32'(level0), 32'd0);
    chk("rst_err", 32'(err0), 32'd0);
    chk("rst_wr_data", 32'(wr_data0), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("ready_after_rst", 32'(in_ready0), 32'd1);
    chk("ready_after_rst1", 32'(in_ready1), 32'd1);

    // Pack mode 1: two samples form one word, low lane first.
    fs1 = 1'b1; tick(); fs1 = 1'b0;
    push1(8'hAA);
    chk("pack_partial_level", 32'(level1), 32'd0);
    push1(8'hBB);
    chk("pack_level", 32'(level1), 32'd1);
    chk("pack_word", 32'(wr_data1), 32'h0000BBAA);
    q1.push_back(16'hBBAA);
    push1(8'h11);
    fs1 = 1'b1; tick(); fs1 = 1'b0;
    for (int i = 0; i < BL - 1; i++) begin
      lo = 8'($urandom); hi = 8'($urandom);
      push1(lo); push1(hi);
      q1.push_back({hi, lo});
    end
    chk("pack_level32", 32'(level1), 32'd32);
    w = 0;
    while (!wr_req1 && w < 50) begin tick(); w++; end
    chk("pack_req", 32'(wr_req1), 32'd1);
    chk("pack_addr", 32'(wr_addr1), 32'd0);
    wr_ack1 = 1'b1; tick(); wr_ack1 = 1'b0;
    for (int i = 0; i < BL; i++) begin
      chk("wr_data1", 32'(wr_data1), 32'(q1.pop_front()));
      wr_pop1 = 1'b1; tick(); wr_pop1 = 1'b0;
    end
    chk("pack_next_addr", 32'(wr_addr1), 32'd32);
    chk("pack_err", 32'(err1), 32'd0);

    // Pack mode 0: 0x01..0x20 from base 0.
    fs0 = 1'b1; tick(); fs0 = 1'b0;
    push0(8'h01);
    chk("level_after_push", 32'(level0), 32'd1);
    for (int i = 2; i <= BL; i++) push0(8'(i));
    start_burst0("b0");
    pops0(BL);
    chk("next_addr_32", 32'(wr_addr0), 32'd32);
    chk("level_drained", 32'(level0), 32'd0);

    // Random bursts walk 32, 64 and wrap to base.
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < BL; i++) push0(8'($urandom));
      start_burst0("wrap");
      pops0(BL);
    end

    // Restart while requesting drops the request and reloads the address.
    for (int i = 0; i < BL; i++) push0(8'($urandom));
    w = 0;
    while (!wr_req0 && w < 50) begin tick(); w++; end
    base0 = 24'd8;
    fs0 = 1'b1; tick(); fs0 = 1'b0;
    m_addr = 8; m_base = 8;
    chk("fs_in_req_drop", 32'(wr_req0), 32'd0);
    chk("fs_in_req_addr", 32'(wr_addr0), 32'd8);
    start_burst0("after_fs");
    pops0(BL);

    // Restart during a burst is deferred to the last pop.
    for (int i = 0; i < BL; i++) push0(8'($urandom));
    start_burst0("defer");
    pops0(10);
    base0 = 24'd100;
    fs0 = 1'b1; tick(); fs0 = 1'b0;
    m_base = 100; m_restart = 1'b1;
    chk("fs_in_burst_hold", 32'(wr_addr0), 32'd40);
    pops0(BL - 10);
    chk("deferred_addr", 32'(wr_addr0), 32'd100);
    base0 = 24'd0;
    fs0 = 1'b1; tick(); fs0 = 1'b0;
    m_addr = 0; m_base = 0;

    // Fill to the brim with no pops, then a pop while a sample waits.
    for (int i = 0; i < 64; i++) push0(8'($urandom));
    chk("full_ready", 32'(in_ready0), 32'd0);
    chk("full_level", 32'(level0), 32'd64);
    held = 8'($urandom);
    in_data0 = held; in_valid0 = 1'b1;
    tick();
    chk("full_blocked_level", 32'(level0), 32'd64);
    start_burst0("full");
    chk("full_head", 32'(wr_data0), 32'(q0[0]));
    void'(q0.pop_front());
    wr_pop0 = 1'b1; tick(); wr_pop0 = 1'b0;
    m_pops++;
    tick();
    in_valid0 = 1'b0;
    q0.push_back({8'h00, held});
    chk("pop_refill_level", 32'(level0), 32'd64);
    pops0(BL - 1);
    start_burst0("full2");
    pops0(BL);
    chk("one_left", 32'(level0), 32'd1);

    // Stray pop in IDLE sets a sticky error and is ignored.
    wr_pop0 = 1'b1; tick(); wr_pop0 = 1'b0;
    chk("err_idle_pop", 32'(err0), 32'd1);
    chk("idle_pop_ignored", 32'(level0), 32'd1);
    for (int i = 0; i < BL - 1; i++) push0(8'($urandom));
    start_burst0("pre_rst");
    pops0(5);
    chk("err_sticky", 32'(err0), 32'd1);
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    q0.delete();
    m_addr = 0; m_pops = 0; m_restart = 0;
    chk("midrst_level", 32'(level0), 32'd0);
    chk("midrst_req", 32'(wr_req0), 32'd0);
    chk("midrst_err", 32'(err0), 32'd0);
    chk("midrst_addr", 32'(wr_addr0), m_addr);
    chk("midrst_ready", 32'(in_ready0), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
